game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Game-flow sequencer for the finish/start overlay stage.
//  - Owns the START / WAIT_PEER / PLAY / WIN / LOSE state machine.
//  - Detects finish-zone arrival of the local and remote player (debounced per frame).
//  - Drives screen_sel to the overlay drawer and freeze/active flags to player logic.
//  - Issues a one-cycle restart pulse; sits between player/UART logic and the draw chain.
// PARAMETERS
//  CONFIRM_FRAMES       4    consecutive frames in zone before a finish is accepted (>=1)
//  HOLD_FRAMES          120  minimum frames WIN/LOSE screen is shown before restart is accepted
//  PEER_TIMEOUT_FRAMES  600  frames WAIT_PEER waits for remote_ready before falling back to START
// PORTS
//  clk           in   1   pixel clock
//  rst           in   1   asynchronous, active-high reset
//  vsync         in   1   VGA vsync from timing chain; rising edge = frame tick
//  start_btn     in   1   synchronised start/restart button, level
//  remote_ready  in   1   peer reports it has started (level, from UART link)
//  level         in   2   local player level
//  x_value       in   12  local player x
//  y_value       in   12  local player y
//  level_rm      in   2   remote player level
//  x_value_rm    in   12  remote player x
//  y_value_rm    in   12  remote player y
//  screen_sel    out  2   screen_t: SCR_GAME / SCR_START / SCR_WIN / SCR_LOSE
//  game_active   out  1   1 only in PLAY
//  freeze        out  1   1 in every state except PLAY (player physics hold)
//  restart_pulse out  1   1-cycle pulse on WIN/LOSE -> START; resets level/position logic
// BEHAVIOUR
//  - Reset (async): state=S_START; screen_sel=SCR_START, game_active=0, freeze=1, restart_pulse=0.
//    All counters and edge registers return to 0.
//  - Frame tick: vsync & ~vsync_d; vsync_d registered.
//  - Button edge: start_btn & ~btn_d; btn_d registered. Only rising edges act.
//  - Zone hit (per player):
//    - Condition: lvl==2'b11 && X_LEFT<x<X_RIGHT && Y_UP<y<Y_DOWN, strict compares.
//    - On each frame tick: cnt = hit ? min(cnt+1, CONFIRM_FRAMES) : 0.
//    - confirm = (cnt==CONFIRM_FRAMES). Both counters clear on entry to PLAY.
//  - FSM (state register, Moore-decoded outputs, visible the cycle the state updates):
//    - S_START: btn edge -> S_PLAY if remote_ready, else S_WAIT_PEER.
//    - S_WAIT_PEER (screen_sel=SCR_START):
//      - remote_ready=1 -> S_PLAY.
//      - Else timeout counter +1 per frame tick; at PEER_TIMEOUT_FRAMES -> S_START.
//      - Button edges are ignored.
//    - S_PLAY (screen_sel=SCR_GAME):
//      - Local confirm -> S_WIN.
//      - Remote confirm -> S_LOSE.
//      - Both confirmed in the same cycle -> S_WIN (local priority).
//    - S_WIN / S_LOSE: outcome latched until leaving the state.
//      - hold_cnt +1 per frame tick, saturating at HOLD_FRAMES; cleared on entry.
//      - Btn edge with hold_cnt==HOLD_FRAMES -> S_START, with restart_pulse=1 for exactly that cycle.
//      - Btn edge before hold expires is discarded; it does not queue.
//  - Counter widths: $clog2(P+1) of the governing parameter; no wrap, all saturate.
//  - Position inputs are sampled only at frame ticks; mid-frame glitches are ignored.
//  - Illegal state encoding -> S_START.
// STRUCTURE
//  - game_pkg:
//    - typedef enum logic [1:0] screen_t.
//    - typedef enum state_t.
//    - FINISH_X_LEFT=500, FINISH_X_RIGHT=628, FINISH_Y_UP=20, FINISH_Y_DOWN=106.
//  - Sub-module finish_zone_det, instantiated twice (local, remote).
//    - Ports: clk, rst, frame_tick, level, x, y -> confirm.
//    - Holds the compare and the saturating confirm counter; clear input driven on PLAY entry.
//  - Top holds the edge detectors, FSM, hold/timeout counters and restart_pulse register.
// TESTING
//  - Reset release: screen_sel=SCR_START, freeze=1.
//    - Btn edge with remote_ready=1 -> next cycle SCR_GAME, game_active=1.
//  - Local at (level 3, x=560, y=50) for 4 frame ticks -> SCR_WIN on the 4th tick.
//    - Leaving the zone after 3 ticks resets the count; no WIN.
//  - Boundary: x=500 or y=106 held 10 frames -> stays SCR_GAME (strict compares).
//  - Local and remote both in zone from the same frame -> SCR_WIN, never SCR_LOSE.
//  - In SCR_LOSE:
//    - Btn at frame 50 -> ignored.
//    - Btn after frame 120 -> restart_pulse one cycle, SCR_START.
//  - Btn with remote_ready=0 -> S_WAIT_PEER; 600 frames -> SCR_START.
//    - Assert rst mid-PLAY -> outputs at reset values immediately (async).

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared types and constants for the game-flow sequencer:
//                overlay screen codes, FSM state encoding, finish-zone box.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        SCR_GAME  = 2'd0,
        SCR_START = 2'd1,
        SCR_WIN   = 2'd2,
        SCR_LOSE  = 2'd3
    } screen_t;

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_WAIT_PEER = 3'd1,
        S_PLAY      = 3'd2,
        S_WIN       = 3'd3,
        S_LOSE      = 3'd4
    } state_t;

    // Finish zone: exclusive bounds on every edge.
    localparam int unsigned FINISH_X_LEFT  = 500;
    localparam int unsigned FINISH_X_RIGHT = 628;
    localparam int unsigned FINISH_Y_UP    = 20;
    localparam int unsigned FINISH_Y_DOWN  = 106;
    // Only a player on the final level can finish.
    localparam logic [1:0]  FINISH_LEVEL   = 2'b11;

    // Screen shown to the overlay drawer for each state. WAIT_PEER keeps
    // the start screen up while the peer is being waited for.
    function automatic screen_t screen_of(input state_t s);
        case (s)
            S_PLAY:  return SCR_GAME;
            S_WIN:   return SCR_WIN;
            S_LOSE:  return SCR_LOSE;
            default: return SCR_START;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/finish_zone_det.sv
`default_nettype none
// ============================================================================
//  Module      : finish_zone_det
//  Description : Per-player finish detector. Samples level/position on each
//                frame tick and counts consecutive in-zone frames, saturating
//                at CONFIRM_FRAMES; confirm_o is high once saturated.
//  Ports       : clk, rst (async, active-high), frame_tick_i, clear_i,
//                level_i[1:0], x_i[11:0], y_i[11:0] -> confirm_o
//  Revision    : 1.0  initial release
// ============================================================================
module finish_zone_det
    import game_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick_i,
    input  logic        clear_i,
    input  logic [1:0]  level_i,
    input  logic [11:0] x_i,
    input  logic [11:0] y_i,
    output logic        confirm_o
);

    localparam int unsigned      CNT_W   = $clog2(CONFIRM_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONFIRM_FRAMES);

    logic [CNT_W-1:0] cnt_q;
    logic             hit_w;

    assign hit_w = (level_i == FINISH_LEVEL)
                && (x_i > 12'(FINISH_X_LEFT)) && (x_i < 12'(FINISH_X_RIGHT))
                && (y_i > 12'(FINISH_Y_UP))   && (y_i < 12'(FINISH_Y_DOWN));

    // Positions only matter at the frame tick, so mid-frame glitches on
    // x/y/level never reach the counter. Clear wins over a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (frame_tick_i) begin
            if (!hit_w) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign confirm_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_flow_ctrl
//  Description : Game-flow sequencer for the finish/start overlay stage.
//                START / WAIT_PEER / PLAY / WIN / LOSE state machine with
//                per-frame finish detection for local and remote players.
//  Ports       : clk, rst (async, active-high)
//                in : vsync_i, start_btn_i, remote_ready_i,
//                     level_i, x_value_i, y_value_i (local player)
//                     level_rm_i, x_value_rm_i, y_value_rm_i (remote player)
//                out: screen_sel_o (screen_t), game_active_o, freeze_o,
//                     restart_pulse_o (1 cycle on WIN/LOSE -> START)
//  Revision    : 1.0  initial release
// ============================================================================
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CONFIRM_FRAMES      = 4,
    parameter int unsigned HOLD_FRAMES         = 120,
    parameter int unsigned PEER_TIMEOUT_FRAMES = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_i,
    input  logic        start_btn_i,
    input  logic        remote_ready_i,
    input  logic [1:0]  level_i,
    input  logic [11:0] x_value_i,
    input  logic [11:0] y_value_i,
    input  logic [1:0]  level_rm_i,
    input  logic [11:0] x_value_rm_i,
    input  logic [11:0] y_value_rm_i,
    output screen_t     screen_sel_o,
    output logic        game_active_o,
    output logic        freeze_o,
    output logic        restart_pulse_o
);

    localparam int unsigned     HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam int unsigned     TO_W     = $clog2(PEER_TIMEOUT_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(PEER_TIMEOUT_FRAMES);

    state_t              state_q, state_d;
    logic                vsync_q, btn_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [TO_W-1:0]     timeout_q;
    logic                frame_tick_w, btn_edge_w;
    logic                enter_play_w, enter_wait_w, enter_end_w;
    logic                local_conf_w, remote_conf_w;

    assign frame_tick_w = vsync_i & ~vsync_q;
    assign btn_edge_w   = start_btn_i & ~btn_q;

    assign enter_play_w = (state_d == S_PLAY) && (state_q != S_PLAY);
    assign enter_wait_w = (state_d == S_WAIT_PEER) && (state_q != S_WAIT_PEER);
    assign enter_end_w  = ((state_d == S_WIN) || (state_d == S_LOSE)) && (state_d != state_q);

    finish_zone_det #(
        .CONFIRM_FRAMES (CONFIRM_FRAMES)
    ) u_det_local (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_w),
        .clear_i      (enter_play_w),
        .level_i      (level_i),
        .x_i          (x_value_i),
        .y_i          (y_value_i),
        .confirm_o    (local_conf_w)
    );

    finish_zone_det #(
        .CONFIRM_FRAMES (CONFIRM_FRAMES)
    ) u_det_remote (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_w),
        .clear_i      (enter_play_w),
        .level_i      (level_rm_i),
        .x_i          (x_value_rm_i),
        .y_i          (y_value_rm_i),
        .confirm_o    (remote_conf_w)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START: begin
                if (btn_edge_w) begin
                    state_d = remote_ready_i ? S_PLAY : S_WAIT_PEER;
                end
            end
            S_WAIT_PEER: begin
                if (remote_ready_i) begin
                    state_d = S_PLAY;
                end else if (timeout_q == TO_MAX) begin
                    state_d = S_START;
                end
            end
            S_PLAY: begin
                // Local player wins a same-cycle tie.
                if (local_conf_w) begin
                    state_d = S_WIN;
                end else if (remote_conf_w) begin
                    state_d = S_LOSE;
                end
            end
            S_WIN, S_LOSE: begin
                // Early presses are simply dropped; nothing is remembered.
                if (btn_edge_w && (hold_q == HOLD_MAX)) begin
                    state_d = S_START;
                end
            end
            default: state_d = S_START;
        endcase
    end

    // Outputs decode the next state so they change in the same cycle as
    // state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_START;
            vsync_q         <= 1'b0;
            btn_q           <= 1'b0;
            hold_q          <= '0;
            timeout_q       <= '0;
            screen_sel_o    <= SCR_START;
            game_active_o   <= 1'b0;
            freeze_o        <= 1'b1;
            restart_pulse_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            vsync_q         <= vsync_i;
            btn_q           <= start_btn_i;
            screen_sel_o    <= screen_of(state_d);
            game_active_o   <= (state_d == S_PLAY);
            freeze_o        <= (state_d != S_PLAY);
            restart_pulse_o <= ((state_q == S_WIN) || (state_q == S_LOSE))
                               && (state_d == S_START);

            if (enter_end_w) begin
                hold_q <= '0;
            end else if (frame_tick_w && (hold_q != HOLD_MAX)) begin
                hold_q <= hold_q + 1'b1;
            end

            if (enter_wait_w) begin
                timeout_q <= '0;
            end else if ((state_q == S_WAIT_PEER) && frame_tick_w && (timeout_q != TO_MAX)) begin
                timeout_q <= timeout_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_flow_ctrl
//  Description : Self-checking bench for game_flow_ctrl: a table of directed
//                vectors (positions, button, frame count -> expected outputs)
//                followed by hand-written restart, async-reset and
//                peer-timeout sequences. A frame is 4 clocks (2 high vsync).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0;
    logic        start_btn = 1'b0;
    logic        remote_ready = 1'b0;
    logic [1:0]  level = '0, level_rm = '0;
    logic [11:0] x_val = '0, y_val = '0, x_rm = '0, y_rm = '0;
    screen_t     screen_sel;
    logic        game_active, freeze, restart_pulse;

    int checks = 0;
    int errors = 0;

    game_flow_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .vsync_i         (vsync),
        .start_btn_i     (start_btn),
        .remote_ready_i  (remote_ready),
        .level_i         (level),
        .x_value_i       (x_val),
        .y_value_i       (y_val),
        .level_rm_i      (level_rm),
        .x_value_rm_i    (x_rm),
        .y_value_rm_i    (y_rm),
        .screen_sel_o    (screen_sel),
        .game_active_o   (game_active),
        .freeze_o        (freeze),
        .restart_pulse_o (restart_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  lvl;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  lvl_rm;
        logic [11:0] xr;
        logic [11:0] yr;
        logic        btn;
        int          nfr;
        screen_t     scr;
        logic        act;
        logic        frz;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vt [NVEC];

    function automatic vec_t mk(input logic [1:0] l, input int x, input int y,
                                input logic [1:0] lr, input int xr, input int yr,
                                input logic b, input int n, input screen_t s);
        vec_t v;
        v.lvl = l;  v.x  = 12'(x);  v.y  = 12'(y);
        v.lvl_rm = lr; v.xr = 12'(xr); v.yr = 12'(yr);
        v.btn = b;  v.nfr = n;  v.scr = s;
        v.act = (s == SCR_GAME);
        v.frz = (s != SCR_GAME);
        return v;
    endfunction

    task automatic chk(input string nm, input screen_t es, input logic ea,
                       input logic ef, input logic ep);
        checks++;
        if (screen_sel !== es || game_active !== ea || freeze !== ef || restart_pulse !== ep) begin
            errors++;
            $display("FAIL %s: got scr=%0d act=%b frz=%b rp=%b, expected scr=%0d act=%b frz=%b rp=%b",
                     nm, screen_sel, game_active, freeze, restart_pulse, es, ea, ef, ep);
        end
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk) vsync = 1'b1;
            @(negedge clk);
            @(negedge clk) vsync = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input logic rr);
        @(negedge clk);
        remote_ready = rr;
        start_btn    = 1'b1;
        @(negedge clk) start_btn = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Out of zone (O), in zone (IN = level 3, 560, 50).
        vt[0]  = mk(0,   0,   0, 0,   0,  0, 0,   0, SCR_START);
        vt[1]  = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_GAME);
        vt[2]  = mk(3, 560,  50, 0,   0,  0, 0,   3, SCR_GAME);
        vt[3]  = mk(3, 700,  50, 0,   0,  0, 0,   1, SCR_GAME);
        vt[4]  = mk(3, 560,  50, 0,   0,  0, 0,   3, SCR_GAME);
        vt[5]  = mk(3, 500,  50, 0,   0,  0, 0,  10, SCR_GAME);
        vt[6]  = mk(3, 560, 106, 0,   0,  0, 0,  10, SCR_GAME);
        vt[7]  = mk(3, 628,  50, 0,   0,  0, 0,  10, SCR_GAME);
        vt[8]  = mk(3, 560,  20, 0,   0,  0, 0,  10, SCR_GAME);
        vt[9]  = mk(2, 560,  50, 0,   0,  0, 0,  10, SCR_GAME);
        vt[10] = mk(3, 501, 105, 0,   0,  0, 0,   4, SCR_WIN);
        vt[11] = mk(0,   0,   0, 0,   0,  0, 0, 130, SCR_WIN);
        vt[12] = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_START);
        vt[13] = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_GAME);
        vt[14] = mk(0,   0,   0, 3, 560, 50, 0,   4, SCR_LOSE);
        vt[15] = mk(0,   0,   0, 0,   0,  0, 0,  46, SCR_LOSE);
        vt[16] = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_LOSE);
        vt[17] = mk(0,   0,   0, 0,   0,  0, 0,  75, SCR_LOSE);
        vt[18] = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_START);
        vt[19] = mk(0,   0,   0, 0,   0,  0, 1,   0, SCR_GAME);
        vt[20] = mk(3, 560,  50, 3, 560, 50, 0,   4, SCR_WIN);

        // Reset asserted, then released.
        repeat (3) @(negedge clk);
        chk("reset_held", SCR_START, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release", SCR_START, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            level = vt[i].lvl;    x_val = vt[i].x;  y_val = vt[i].y;
            level_rm = vt[i].lvl_rm; x_rm = vt[i].xr; y_rm = vt[i].yr;
            if (vt[i].btn) press(1'b1);
            frames(vt[i].nfr);
            chk($sformatf("vec%0d", i), vt[i].scr, vt[i].act, vt[i].frz, 1'b0);
        end

        // Restart from WIN after the hold period: exactly one pulse cycle.
        level = '0; x_val = '0; y_val = '0; level_rm = '0; x_rm = '0; y_rm = '0;
        frames(120);
        @(negedge clk);
        remote_ready = 1'b1;
        start_btn    = 1'b1;
        @(negedge clk) start_btn = 1'b0;
        chk("restart_pulse_hi", SCR_START, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("restart_pulse_lo", SCR_START, 1'b0, 1'b1, 1'b0);

        // Async reset in the middle of PLAY.
        press(1'b1);
        chk("play_before_rst", SCR_GAME, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_rst", SCR_START, 1'b0, 1'b1, 1'b0);
        @(negedge clk) rst = 1'b0;

        // WAIT_PEER: still waiting after 599 frames, peer joins -> PLAY.
        press(1'b0);
        chk("wait_peer_screen", SCR_START, 1'b0, 1'b1, 1'b0);
        frames(599);
        remote_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wait_599_join", SCR_GAME, 1'b1, 1'b0, 1'b0);

        @(negedge clk) rst = 1'b1;
        remote_ready = 1'b0;
        @(negedge clk) rst = 1'b0;

        // WAIT_PEER: 600 frames -> back to START; late peer does not start.
        press(1'b0);
        frames(600);
        remote_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_timeout", SCR_START, 1'b0, 1'b1, 1'b0);
        press(1'b1);
        chk("start_after_timeout", SCR_GAME, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
